// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates a branch condition, computes target/next PC,
// and tracks a small table of 2-bit saturating counters for misprediction flags.
module branch_unit #(
  parameter int N = 8,
  parameter int A = 8,
  parameter int D = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] rdata1,
  input  logic [N-1:0] rdata2,
  input  logic [2:0]   cond,
  input  logic [A-1:0] pc,
  input  logic [A-1:0] offset,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         taken,
  output logic         lt,
  output logic [A-1:0] target,
  output logic [A-1:0] next_pc,
  output logic         mispredict
);

  localparam int IW = $clog2(D);

  logic         out_valid_q;
  logic         taken_q, taken_d;
  logic         lt_q, lt_d;
  logic [A-1:0] target_q, target_d;
  logic [A-1:0] next_pc_q, next_pc_d;
  logic         mispredict_q, mispredict_d;
  logic [1:0]   ctr_q [D];
  logic [IW-1:0] idx;
  logic         predicted;
  logic         accept;

  function automatic logic cond_eval(input logic [2:0] c,
                                     input logic [N-1:0] a,
                                     input logic [N-1:0] b);
    logic r;
    case (c)
      3'b000:  r = (a == b);
      3'b001:  r = (a != b);
      3'b010:  r = 1'b1;
      3'b011:  r = 1'b0;
      3'b100:  r = ($signed(a) < $signed(b));
      3'b101:  r = !($signed(a) < $signed(b));
      3'b110:  r = (a < b);
      default: r = !(a < b);
    endcase
    return r;
  endfunction

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    logic [1:0] r;
    if (up) r = (c == 2'b11) ? c : c + 2'b01;
    else    r = (c == 2'b00) ? c : c - 2'b01;
    return r;
  endfunction

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign idx      = pc[IW-1:0];

  always_comb begin
    taken_d      = cond_eval(cond, rdata1, rdata2);
    lt_d         = ($signed(rdata1) < $signed(rdata2));
    target_d     = pc + offset;
    next_pc_d    = taken_d ? target_d : pc + A'(1);
    // Prediction comes from the counter as it stood before this request trains it.
    predicted    = ctr_q[idx][1];
    mispredict_d = taken_d ^ predicted;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      lt_q         <= 1'b0;
      target_q     <= '0;
      next_pc_q    <= '0;
      mispredict_q <= 1'b0;
      for (int i = 0; i < D; i++) ctr_q[i] <= 2'b01;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      taken_q      <= taken_d;
      lt_q         <= lt_d;
      target_q     <= target_d;
      next_pc_q    <= next_pc_d;
      mispredict_q <= mispredict_d;
      ctr_q[idx]   <= sat_step(ctr_q[idx], taken_d);
    end else if (out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign taken      = taken_q;
  assign lt         = lt_q;
  assign target     = target_q;
  assign next_pc    = next_pc_q;
  assign mispredict = mispredict_q;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: the driver pushes model results on acceptance,
// a negedge monitor compares whatever the DUT is presenting against the queue head.
module tb_branch_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] rdata1 = '0, rdata2 = '0;
  logic [2:0] cond = '0;
  logic [7:0] pc = '0, offset = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       taken, lt, mispredict;
  logic [7:0] target, next_pc;

  branch_unit #(.N(8), .A(8), .D(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rdata1(rdata1), .rdata2(rdata2), .cond(cond), .pc(pc), .offset(offset),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .lt(lt),
    .target(target), .next_pc(next_pc), .mispredict(mispredict)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit tk;
    bit lt;
    bit mp;
    int tgt;
    int npc;
  } exp_t;

  exp_t q[$];
  int   ctr[4];
  bit   mvalid;
  int   npass = 0;
  int   ntot  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
  endtask

  // Reference model: plain integer arithmetic on the condition rules.
  function automatic exp_t model(input int r1, input int r2, input int c, input int p, input int o);
    exp_t e;
    int s1, s2, ix;
    bit pred;
    s1 = (r1 >= 128) ? r1 - 256 : r1;
    s2 = (r2 >= 128) ? r2 - 256 : r2;
    case (c)
      0: e.tk = (r1 == r2);
      1: e.tk = (r1 != r2);
      2: e.tk = 1;
      3: e.tk = 0;
      4: e.tk = (s1 < s2);
      5: e.tk = (s1 >= s2);
      6: e.tk = (r1 < r2);
      default: e.tk = (r1 >= r2);
    endcase
    e.lt  = (s1 < s2);
    e.tgt = (p + o) % 256;
    e.npc = e.tk ? e.tgt : (p + 1) % 256;
    ix    = p % 4;
    pred  = (ctr[ix] >= 2);
    e.mp  = (e.tk != pred);
    if (e.tk) ctr[ix] = (ctr[ix] == 3) ? 3 : ctr[ix] + 1;
    else      ctr[ix] = (ctr[ix] == 0) ? 0 : ctr[ix] - 1;
    return e;
  endfunction

  // Called just after a rising edge; ends just after the next rising edge.
  task automatic cycle(input bit iv, input int r1, input int r2, input int c,
                       input int p, input int o, input bit ordy);
    bit   acc;
    exp_t e;
    in_valid  = iv;
    rdata1    = r1[7:0];
    rdata2    = r2[7:0];
    cond      = c[2:0];
    pc        = p[7:0];
    offset    = o[7:0];
    out_ready = ordy;
    @(negedge clock);
    chk("in_ready", int'(in_ready), int'(!mvalid || ordy));
    acc = iv && (!mvalid || ordy);
    if (acc) e = model(r1, r2, c, p, o);
    @(posedge clock);
    if (acc) begin
      q.push_back(e);
      mvalid = 1;
    end else if (ordy) begin
      mvalid = 0;
    end
    #1;
  endtask

  task automatic do_reset(input bit iv);
    reset    = 1'b1;
    in_valid = iv;
    out_ready = 1'b0;
    @(posedge clock);
    q.delete();
    mvalid = 0;
    for (int i = 0; i < 4; i++) ctr[i] = 1;
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_taken", int'(taken), 0);
    chk("rst_lt", int'(lt), 0);
    chk("rst_mispredict", int'(mispredict), 0);
    chk("rst_target", int'(target), 0);
    chk("rst_next_pc", int'(next_pc), 0);
    @(posedge clock);
    #1;
  endtask

  // Monitor: whatever the DUT presents must match the queue head, held until consumed.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("out_valid", int'(out_valid), int'(q.size() != 0));
        if (out_valid && q.size() != 0) begin
          chk("taken", int'(taken), int'(q[0].tk));
          chk("lt", int'(lt), int'(q[0].lt));
          chk("target", int'(target), q[0].tgt);
          chk("next_pc", int'(next_pc), q[0].npc);
          chk("mispredict", int'(mispredict), int'(q[0].mp));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mvalid = 0;
    for (int i = 0; i < 4; i++) ctr[i] = 1;
    @(posedge clock);
    #1;
    do_reset(1'b0);

    // Signed vs unsigned compare
    cycle(1, 'hFF, 'h01, 4, 'h10, 'h03, 1);
    cycle(1, 'hFF, 'h01, 6, 'h10, 'h03, 1);
    // Target wrap
    cycle(1, 'h00, 'h00, 2, 'hF0, 'h20, 1);
    cycle(1, 'h00, 'h00, 3, 'hF0, 'h20, 1);
    // Backpressure: stall three cycles while requests are offered, then release
    cycle(1, 'h12, 'h34, 1, 'h21, 'h05, 0);
    for (int i = 0; i < 3; i++) cycle(1, 'h40 + i, 'h40, 5, 'h30 + i, 'h7F, 0);
    cycle(1, 'h80, 'h7F, 7, 'h33, 'hFE, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // Predictor training and untraining at pc 0x04
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) cycle(1, 'h05, 'h05, 0, 'h04, 'h10, 1);
    for (int i = 0; i < 2; i++) cycle(1, 'h05, 'h06, 0, 'h04, 'h10, 1);
    cycle(1, 'h05, 'h05, 0, 'h04, 'h10, 1);
    cycle(1, 'h05, 'h05, 0, 'h04, 'h10, 1);

    // Reset mid-operation with a held result and a request on the inputs
    cycle(1, 'h01, 'h01, 0, 'h04, 'h02, 0);
    do_reset(1'b1);
    cycle(1, 'h09, 'h09, 0, 'h04, 'h02, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      int r1, r2;
      r1 = $urandom_range(0, 255);
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom_range(0, 255);
      cycle(bit'($urandom_range(0, 3) != 0), r1, r2, $urandom_range(0, 7),
            $urandom_range(0, 255), $urandom_range(0, 255),
            bit'($urandom_range(0, 9) < 7));
    end

    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1);
    chk("drain_empty", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
